// File: rtl/encoder_32to5.sv
// encoder_32to5: registered 32-to-5 request encoder with a valid/ready output slot.
// Sticky request bits accumulate in a pending vector; one pending index per cycle
// is loaded into the output slot and cleared from the vector.
// Optional build macro: ENCODER_RR_EN selects round-robin instead of lowest-index
// priority (adds a 5-bit rr_ptr that tracks the last loaded index + 1).
module encoder_32to5 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_in,
    output logic [4:0]  out_idx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] pending
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [4:0]  out_idx_q, out_idx_d;
    logic        load;
    logic [4:0]  sel_idx;
    logic [31:0] clr_mask;
    logic        any_pending;

    assign any_pending = |pending_q;

`ifdef ENCODER_RR_EN
    logic [4:0]  rr_ptr_q, rr_ptr_d;
    logic [31:0] rot_pending;
    logic [4:0]  rot_off;

    // Rotate pending so that rr_ptr lands at bit 0, then pick the lowest set bit;
    // adding rr_ptr back (mod 32) gives the wrap-around upward search.
    always_comb begin
        rot_pending = (pending_q >> rr_ptr_q) | (pending_q << (6'd32 - {1'b0, rr_ptr_q}));
        rot_off     = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (rot_pending[i]) begin
                rot_off = 5'(i);
            end
        end
        sel_idx = rr_ptr_q + rot_off;
    end

    // Pointer moves past the index just loaded; untouched when nothing loads.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (load) begin
            rr_ptr_d = sel_idx + 5'd1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 5'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed priority: the lowest set pending bit wins.
    always_comb begin
        sel_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_idx = 5'(i);
            end
        end
    end
`endif

    // One-hot clear mask on the index being loaded this cycle.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_clr
            assign clr_mask[gi] = load && (sel_idx == 5'(gi));
        end
    endgenerate

    // Slot next-state and load decision; a refill while FULL gives back-to-back transfers.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        out_idx_d = out_idx_q;
        case (state_q)
            EMPTY: begin
                if (any_pending) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    if (any_pending) begin
                        load = 1'b1;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (load) begin
            out_idx_d = sel_idx;
        end
    end

    // Sets win over the clear of the same bit, so a re-request is served again.
    assign pending_d = (pending_q & ~clr_mask) | req_in;

    // State, slot and pending registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            out_idx_q <= 5'd0;
            pending_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            out_idx_q <= out_idx_d;
            pending_q <= pending_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_idx   = out_idx_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_encoder_32to5.sv
// Testbench for encoder_32to5: table of one-shot request pulses checked through a
// handshake scoreboard, plus hand-written sequences for latency, backpressure,
// set/clear collision, held requests and reset in mid-operation.
module tb_encoder_32to5;

    logic        clk;
    logic        rst;
    logic [31:0] req_in;
    logic [4:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pending;

    int checks = 0;
    int errors = 0;
    bit sb_en  = 1'b0;
    logic [4:0] exp_q[$];

    typedef struct packed {
        logic [31:0]     req;
        logic [2:0]      n;
        logic [3:0][4:0] idx;
    } vec_t;

    vec_t table_v[6];

    encoder_32to5 dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sb_en     = 1'b0;
        rst       = 1'b1;
        req_in    = 32'h0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Scoreboard: every accepted transfer pops one expected index.
    always @(negedge clk) begin
        if (sb_en && !rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got idx %0d expected none", out_idx);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                if (out_idx !== e) begin
                    errors++;
                    $display("FAIL sb_idx: got %0d expected %0d", out_idx, e);
                end else begin
                    $display("ok   sb_idx: %0d", out_idx);
                end
            end
        end
    end

    initial begin
        logic [4:0] rr_seq[3];
        rr_seq[0] = 5'd0;
        rr_seq[1] = 5'd1;
        rr_seq[2] = 5'd31;

        table_v[0] = '{req: 32'h0000_0400, n: 3'd1, idx: {5'd0,  5'd0,  5'd0,  5'd10}};
        table_v[1] = '{req: 32'h8000_0000, n: 3'd1, idx: {5'd0,  5'd0,  5'd0,  5'd31}};
        table_v[2] = '{req: 32'h0000_0001, n: 3'd1, idx: {5'd0,  5'd0,  5'd0,  5'd0}};
        table_v[3] = '{req: 32'h0001_0100, n: 3'd2, idx: {5'd0,  5'd0,  5'd16, 5'd8}};
        table_v[4] = '{req: 32'hC000_0002, n: 3'd3, idx: {5'd0,  5'd31, 5'd30, 5'd1}};
        table_v[5] = '{req: 32'h0000_000F, n: 3'd4, idx: {5'd3,  5'd2,  5'd1,  5'd0}};

        // Reset with all requests asserted: nothing may survive.
        rst       = 1'b1;
        req_in    = 32'hFFFF_FFFF;
        out_ready = 1'b0;
        tick();
        tick();
        rst    = 1'b0;
        req_in = 32'h0;
        chk("rst_pending", pending, 32'h0);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_idx", {27'h0, out_idx}, 32'h0);
        tick();
        chk("idle_pending", pending, 32'h0);
        chk("idle_valid", {31'h0, out_valid}, 32'h0);

        // Single request: two-cycle latency, one-cycle valid.
        do_reset();
        sb_en     = 1'b1;
        out_ready = 1'b1;
        req_in    = 32'h0000_0400;
        exp_q.push_back(5'd10);
        tick();
        req_in = 32'h0;
        chk("lat_valid_n1", {31'h0, out_valid}, 32'h0);
        chk("lat_pending_n1", pending, 32'h0000_0400);
        tick();
        chk("lat_valid_n2", {31'h0, out_valid}, 32'h1);
        chk("lat_idx_n2", {27'h0, out_idx}, 32'd10);
        chk("lat_pending_n2", pending, 32'h0);
        tick();
        chk("lat_valid_n3", {31'h0, out_valid}, 32'h0);
        chk("lat_sb_empty", exp_q.size(), 32'd0);

        // Table of one-shot pulses drained through the scoreboard.
        for (int t = 0; t < 6; t++) begin
            int budget;
            do_reset();
            sb_en     = 1'b1;
            out_ready = 1'b1;
            req_in    = table_v[t].req;
            for (int k = 0; k < int'(table_v[t].n); k++) begin
                exp_q.push_back(table_v[t].idx[k]);
            end
            tick();
            req_in = 32'h0;
            budget = 0;
            while (exp_q.size() != 0 && budget < 20) begin
                tick();
                budget++;
            end
            tick();
            chk($sformatf("tbl%0d_drained", t), exp_q.size(), 32'd0);
            chk($sformatf("tbl%0d_pending", t), pending, 32'h0);
            chk($sformatf("tbl%0d_valid", t), {31'h0, out_valid}, 32'h0);
        end

        // Backpressure: index 0 held while out_ready=0, then 31, then empty.
        do_reset();
        sb_en     = 1'b1;
        out_ready = 1'b0;
        req_in    = 32'h8000_0001;
        exp_q.push_back(5'd0);
        exp_q.push_back(5'd31);
        tick();
        req_in = 32'h0;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_valid_%0d", k), {31'h0, out_valid}, 32'h1);
            chk($sformatf("bp_idx_%0d", k), {27'h0, out_idx}, 32'd0);
            if (k == 4) out_ready = 1'b1;
            tick();
        end
        chk("bp_idx_31", {27'h0, out_idx}, 32'd31);
        chk("bp_valid_31", {31'h0, out_valid}, 32'h1);
        tick();
        chk("bp_valid_end", {31'h0, out_valid}, 32'h0);
        chk("bp_sb_empty", exp_q.size(), 32'd0);

        // Set/clear collision: bit 3 re-requested in the cycle it is loaded.
        do_reset();
        sb_en     = 1'b1;
        out_ready = 1'b1;
        req_in    = 32'h0000_0008;
        exp_q.push_back(5'd3);
        exp_q.push_back(5'd3);
        tick();
        chk("col_pending_n1", pending, 32'h0000_0008);
        tick();
        req_in = 32'h0;
        chk("col_pending_kept", pending, 32'h0000_0008);
        chk("col_idx_first", {27'h0, out_idx}, 32'd3);
        tick();
        chk("col_valid_second", {31'h0, out_valid}, 32'h1);
        chk("col_idx_second", {27'h0, out_idx}, 32'd3);
        chk("col_pending_end", pending, 32'h0);
        tick();
        chk("col_valid_end", {31'h0, out_valid}, 32'h0);
        chk("col_sb_empty", exp_q.size(), 32'd0);

        // Held request vector: round-robin rotates, fixed priority repeats index 0.
        do_reset();
        out_ready = 1'b1;
        req_in    = 32'h8000_0003;
        tick();
        tick();
        for (int k = 0; k < 6; k++) begin
            logic [4:0] e;
`ifdef ENCODER_RR_EN
            e = rr_seq[k % 3];
`else
            e = 5'd0;
`endif
            chk($sformatf("hold_valid_%0d", k), {31'h0, out_valid}, 32'h1);
            chk($sformatf("hold_idx_%0d", k), {27'h0, out_idx}, {27'h0, e});
            tick();
        end

        // Reset in mid-operation with a full slot and pending bits.
        do_reset();
        out_ready = 1'b0;
        req_in    = 32'h0000_0010;
        tick();
        req_in = 32'h0;
        tick();
        req_in = 32'h0000_00F0;
        tick();
        req_in = 32'h0;
        chk("mid_pending", pending, 32'h0000_00F0);
        chk("mid_valid", {31'h0, out_valid}, 32'h1);
        chk("mid_idx", {27'h0, out_idx}, 32'd4);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_pending", pending, 32'h0);
        begin
            int stale;
            stale = 0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (out_valid) stale++;
            end
            chk("mid_no_stale", stale, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
